ticket_sale_ctrl: RTL and testbench

Ticket-vending control FSM. It registers the passenger's ticket selection, accumulates inserted coins, dispenses tickets one at a time and computes change. It sits directly upstream of the display digit-split stage. That stage consumes money, ticketType, ticketCount and moneyReturn from this block and renders them as BCD digits. Its ticketSum pricing must match this block exactly.

---
 rtl/ticket_pkg.sv | 28 ++
 rtl/ticket_sale_ctrl_coin_decoder.sv | 24 ++
 rtl/ticket_sale_ctrl.sv | 144 ++++++++++++++
 tb/tb_ticket_sale_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ticket_pkg.sv
// Shared definitions for the ticket vending controller and the display stage.
// Both blocks price tickets through ticket_price so their ticketSum values always agree.
package ticket_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY  = 2'd1,
        VEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] COIN_1  = 8'd1;
    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;
    localparam logic [7:0] COIN_20 = 8'd20;
    localparam logic [7:0] COIN_50 = 8'd50;

    // Types 4..7 are not distinct products and are charged the top fare.
    function automatic logic [7:0] ticket_price(input logic [2:0] ticketType);
        case (ticketType)
            3'd0:    ticket_price = 8'd5;
            3'd1:    ticket_price = 8'd10;
            3'd2:    ticket_price = 8'd20;
            default: ticket_price = 8'd30;
        endcase
    endfunction

endpackage

// File: rtl/ticket_sale_ctrl_coin_decoder.sv
// Maps a one-hot coin pulse vector to its yuan value.
// Anything other than exactly one bit set decodes as invalid with value zero.
module coin_decoder
    import ticket_pkg::*;
(
    input  logic [4:0] coin,
    output logic [7:0] coinValue,
    output logic       coinValid
);

    always_comb begin
        coinValue = 8'd0;
        coinValid = 1'b1;
        case (coin)
            5'b00001: coinValue = COIN_1;
            5'b00010: coinValue = COIN_5;
            5'b00100: coinValue = COIN_10;
            5'b01000: coinValue = COIN_20;
            5'b10000: coinValue = COIN_50;
            default:  coinValid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ticket_sale_ctrl.sv
// Ticket vending control FSM: latches the selection, collects coins,
// dispenses tickets one per DISP_GAP cycles and reports change or refund.
module ticket_sale_ctrl
    import ticket_pkg::*;
#(
    parameter int MAX_MONEY   = 250,
    parameter int DISP_GAP    = 4,
    parameter int HOLD_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] selType,
    input  logic [2:0] selCount,
    input  logic       start,
    input  logic       cancel,
    input  logic [4:0] coin,
    output logic [2:0] ticketType,
    output logic [2:0] ticketCount,
    output logic [7:0] money,
    output logic [7:0] moneyReturn,
    output logic       ticketOut,
    output logic       coinReject,
    output logic       done
);

    localparam int GW = $clog2(DISP_GAP + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t         state_q, state_d;
    logic [7:0]     money_q, money_d;
    logic [7:0]     moneyReturn_q, moneyReturn_d;
    logic [2:0]     ticketType_q, ticketType_d;
    logic [2:0]     ticketCount_q, ticketCount_d;
    logic           coinReject_q, coinReject_d;
    logic [2:0]     remain_q, remain_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [7:0]     coinValue;
    logic           coinValid;
    logic           coinAny;
    logic [8:0]     creditSum;
    logic [7:0]     ticketSum;

    coin_decoder u_coin_decoder (
        .coin      (coin),
        .coinValue (coinValue),
        .coinValid (coinValid)
    );

    assign coinAny   = |coin;
    assign creditSum = {1'b0, money_q} + {1'b0, coinValue};
    assign ticketSum = ticket_price(ticketType_q) * {5'd0, ticketCount_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            money_q       <= 8'd0;
            moneyReturn_q <= 8'd0;
            ticketType_q  <= 3'd0;
            ticketCount_q <= 3'd0;
            coinReject_q  <= 1'b0;
            remain_q      <= 3'd0;
            gap_q         <= '0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            money_q       <= money_d;
            moneyReturn_q <= moneyReturn_d;
            ticketType_q  <= ticketType_d;
            ticketCount_q <= ticketCount_d;
            coinReject_q  <= coinReject_d;
            remain_q      <= remain_d;
            gap_q         <= gap_d;
            hold_q        <= hold_d;
        end
    end

    // Any coin not explicitly credited in PAY is bounced back the following cycle.
    always_comb begin
        state_d       = state_q;
        money_d       = money_q;
        moneyReturn_d = moneyReturn_q;
        ticketType_d  = ticketType_q;
        ticketCount_d = ticketCount_q;
        coinReject_d  = coinAny;
        remain_d      = remain_q;
        gap_d         = gap_q;
        hold_d        = hold_q;
        case (state_q)
            IDLE: begin
                ticketType_d  = selType;
                ticketCount_d = selCount;
                if (start && selCount != 3'd0) state_d = PAY;
            end
            PAY: begin
                if (cancel) begin
                    moneyReturn_d = money_q;
                    hold_d        = '0;
                    state_d       = DONE;
                end else if (money_q >= ticketSum) begin
                    remain_d = ticketCount_q;
                    gap_d    = '0;
                    state_d  = VEND;
                end else if (coinValid && creditSum <= 9'(MAX_MONEY)) begin
                    money_d      = creditSum[7:0];
                    coinReject_d = 1'b0;
                end
            end
            VEND: begin
                if (remain_q == 3'd0) begin
                    moneyReturn_d = money_q - ticketSum;
                    hold_d        = '0;
                    state_d       = DONE;
                end else if (gap_q == '0) begin
                    remain_d = remain_q - 3'd1;
                    gap_d    = GW'(DISP_GAP - 1);
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            DONE: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    money_d       = 8'd0;
                    moneyReturn_d = 8'd0;
                    hold_d        = '0;
                    state_d       = IDLE;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ticketType  = ticketType_q;
    assign ticketCount = ticketCount_q;
    assign money       = money_q;
    assign moneyReturn = moneyReturn_q;
    assign coinReject  = coinReject_q;
    assign ticketOut   = (state_q == VEND) && (remain_q != 3'd0) && (gap_q == '0);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_ticket_sale_ctrl.sv
// Directed self-checking bench for ticket_sale_ctrl with a short DONE hold time.
module tb_ticket_sale_ctrl;

    localparam int HOLD = 8;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] selType, selCount;
    logic       start, cancel;
    logic [4:0] coin;
    logic [2:0] ticketType, ticketCount;
    logic [7:0] money, moneyReturn;
    logic       ticketOut, coinReject, done;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] C1 = 5'b00001, C5 = 5'b00010, C10 = 5'b00100, C20 = 5'b01000, C50 = 5'b10000;

    ticket_sale_ctrl #(.MAX_MONEY(250), .DISP_GAP(GAP), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .selType(selType), .selCount(selCount),
        .start(start), .cancel(cancel), .coin(coin),
        .ticketType(ticketType), .ticketCount(ticketCount), .money(money),
        .moneyReturn(moneyReturn), .ticketOut(ticketOut), .coinReject(coinReject), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] t, input logic [2:0] c);
        selType = t; selCount = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic insertCoin(input logic [4:0] c);
        coin = c;
        tick();
        coin = 5'd0;
    endtask

    // Watches vending and the DONE hold, from the current sample until DONE ends.
    task automatic observe(output int pulses, output int gap, output int doneLen,
                           output logic [7:0] ret, output logic [7:0] moneyAfter, output bit timeout);
        int firstIdx = -1;
        bit seenDone = 1'b0;
        pulses = 0; gap = -1; doneLen = 0; ret = 8'hFF; moneyAfter = 8'hFF; timeout = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (ticketOut) begin
                pulses++;
                if (firstIdx < 0) firstIdx = i;
                else if (gap < 0) gap = i - firstIdx;
            end
            if (done) begin
                if (!seenDone) ret = moneyReturn;
                seenDone = 1'b1;
                doneLen++;
            end else if (seenDone) begin
                moneyAfter = money;
                timeout = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; selType = 3'd3; selCount = 3'd5; start = 1'b0; cancel = 1'b0; coin = 5'd0;
        tick(); tick();
        checks++; if (money !== 8'd0 || moneyReturn !== 8'd0) begin errors++; $display("[TB] FAIL reset_money: money=%0d ret=%0d required 0/0", money, moneyReturn); end
        checks++; if (ticketType !== 3'd0 || ticketCount !== 3'd0) begin errors++; $display("[TB] FAIL reset_sel: type=%0d count=%0d required 0/0", ticketType, ticketCount); end
        checks++; if ({ticketOut, coinReject, done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: %b required 000", {ticketOut, coinReject, done}); end
        rst = 1'b0;
        tick();
        checks++; if (ticketType !== 3'd3 || ticketCount !== 3'd5) begin errors++; $display("[TB] FAIL idle_preview: type=%0d count=%0d required 3/5", ticketType, ticketCount); end
    endtask

    task automatic test_two_tickets();
        int p, g, dl; logic [7:0] r, ma; bit to;
        applyStimulus(3'd1, 3'd2);
        checks++; if (ticketType !== 3'd1 || ticketCount !== 3'd2) begin errors++; $display("[TB] FAIL latch_sel: type=%0d count=%0d required 1/2", ticketType, ticketCount); end
        selType = 3'd5; selCount = 3'd3;
        insertCoin(C20);
        checks++; if (money !== 8'd20) begin errors++; $display("[TB] FAIL t1_money: got %0d required 20", money); end
        checks++; if (ticketType !== 3'd1 || ticketCount !== 3'd2) begin errors++; $display("[TB] FAIL t1_frozen: type=%0d count=%0d required 1/2", ticketType, ticketCount); end
        checks++; if (ticketOut !== 1'b0) begin errors++; $display("[TB] FAIL t1_early_pulse: ticketOut=%b required 0", ticketOut); end
        tick();
        checks++; if (ticketOut !== 1'b1) begin errors++; $display("[TB] FAIL t1_first_pulse: ticketOut=%b required 1", ticketOut); end
        observe(p, g, dl, r, ma, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL t1_timeout: DONE never ended"); end
        checks++; if (p != 2 || g != GAP) begin errors++; $display("[TB] FAIL t1_pulses: count=%0d gap=%0d required 2/%0d", p, g, GAP); end
        checks++; if (r !== 8'd0) begin errors++; $display("[TB] FAIL t1_return: got %0d required 0", r); end
        checks++; if (dl != HOLD) begin errors++; $display("[TB] FAIL t1_hold: got %0d required %0d", dl, HOLD); end
        checks++; if (ma !== 8'd0) begin errors++; $display("[TB] FAIL t1_money_clear: got %0d required 0", ma); end
    endtask

    task automatic test_change();
        int p, g, dl; logic [7:0] r, ma; bit to;
        applyStimulus(3'd3, 3'd1);
        insertCoin(C50);
        checks++; if (money !== 8'd50) begin errors++; $display("[TB] FAIL t2_money: got %0d required 50", money); end
        observe(p, g, dl, r, ma, to);
        checks++; if (to || p != 1 || r !== 8'd20) begin errors++; $display("[TB] FAIL t2_change: pulses=%0d ret=%0d to=%0d required 1/20/0", p, r, to); end
    endtask

    task automatic test_cancel();
        int p, g, dl; logic [7:0] r, ma; bit to;
        applyStimulus(3'd0, 3'd7);
        insertCoin(C20);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (done !== 1'b1 || moneyReturn !== 8'd20) begin errors++; $display("[TB] FAIL t3_cancel: done=%b ret=%0d required 1/20", done, moneyReturn); end
        observe(p, g, dl, r, ma, to);
        checks++; if (to || p != 0 || dl != HOLD || ma !== 8'd0) begin errors++; $display("[TB] FAIL t3_refund: pulses=%0d hold=%0d after=%0d to=%0d required 0/%0d/0/0", p, dl, ma, to, HOLD); end
    endtask

    task automatic test_max_money();
        int p, g, dl; logic [7:0] r, ma; bit to;
        applyStimulus(3'd3, 3'd7);
        for (int i = 0; i < 4; i++) insertCoin(C50);
        checks++; if (money !== 8'd200) begin errors++; $display("[TB] FAIL t4_200: got %0d required 200", money); end
        insertCoin(C1);
        checks++; if (money !== 8'd201 || coinReject !== 1'b0) begin errors++; $display("[TB] FAIL t4_201: money=%0d rej=%b required 201/0", money, coinReject); end
        insertCoin(C50);
        checks++; if (money !== 8'd201 || coinReject !== 1'b1) begin errors++; $display("[TB] FAIL t4_over: money=%0d rej=%b required 201/1", money, coinReject); end
        insertCoin(C20);
        checks++; if (money !== 8'd221 || coinReject !== 1'b0) begin errors++; $display("[TB] FAIL t4_221: money=%0d rej=%b required 221/0", money, coinReject); end
        observe(p, g, dl, r, ma, to);
        checks++; if (to || p != 7 || g != GAP || r !== 8'd11) begin errors++; $display("[TB] FAIL t4_vend: pulses=%0d gap=%0d ret=%0d to=%0d required 7/%0d/11/0", p, g, r, to, GAP); end
    endtask

    task automatic test_exact_max();
        int p, g, dl; logic [7:0] r, ma; bit to;
        applyStimulus(3'd3, 3'd7);
        for (int i = 0; i < 5; i++) insertCoin(C50);
        checks++; if (money !== 8'd250 || coinReject !== 1'b0) begin errors++; $display("[TB] FAIL t4b_250: money=%0d rej=%b required 250/0", money, coinReject); end
        observe(p, g, dl, r, ma, to);
        checks++; if (to || p != 7 || r !== 8'd40) begin errors++; $display("[TB] FAIL t4b_vend: pulses=%0d ret=%0d to=%0d required 7/40/0", p, r, to); end
    endtask

    task automatic test_rejects();
        int p, g, dl; logic [7:0] r, ma; bit to;
        applyStimulus(3'd1, 3'd1);
        insertCoin(5'b00011);
        checks++; if (coinReject !== 1'b1 || money !== 8'd0) begin errors++; $display("[TB] FAIL t5_multi: rej=%b money=%0d required 1/0", coinReject, money); end
        tick();
        checks++; if (coinReject !== 1'b0) begin errors++; $display("[TB] FAIL t5_single_pulse: rej=%b required 0", coinReject); end
        cancel = 1'b1; coin = C1;
        tick();
        cancel = 1'b0; coin = 5'd0;
        checks++; if (coinReject !== 1'b1 || done !== 1'b1 || money !== 8'd0) begin errors++; $display("[TB] FAIL t5_cancel_coin: rej=%b done=%b money=%0d required 1/1/0", coinReject, done, money); end
        observe(p, g, dl, r, ma, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL t5_timeout: DONE never ended"); end
        insertCoin(C10);
        checks++; if (coinReject !== 1'b1 || money !== 8'd0) begin errors++; $display("[TB] FAIL t5_idle_coin: rej=%b money=%0d required 1/0", coinReject, money); end
        applyStimulus(3'd2, 3'd0);
        checks++; if (ticketType !== 3'd2 || ticketCount !== 3'd0) begin errors++; $display("[TB] FAIL t5_preview: type=%0d count=%0d required 2/0", ticketType, ticketCount); end
        insertCoin(C10);
        checks++; if (coinReject !== 1'b1 || money !== 8'd0 || done !== 1'b0) begin errors++; $display("[TB] FAIL t5_zero_count: rej=%b money=%0d done=%b required 1/0/0", coinReject, money, done); end
    endtask

    task automatic test_back_to_back();
        int p, g, dl; logic [7:0] r, ma; bit to;
        applyStimulus(3'd0, 3'd1);
        insertCoin(C5);
        insertCoin(C1);
        checks++; if (coinReject !== 1'b1 || money !== 8'd5 || ticketOut !== 1'b1) begin errors++; $display("[TB] FAIL vend_entry_coin: rej=%b money=%0d out=%b required 1/5/1", coinReject, money, ticketOut); end
        observe(p, g, dl, r, ma, to);
        checks++; if (to || p != 1 || r !== 8'd0) begin errors++; $display("[TB] FAIL vend_entry_done: pulses=%0d ret=%0d to=%0d required 1/0/0", p, r, to); end
    endtask

    task automatic test_reset_mid_vend();
        int extra = 0;
        applyStimulus(3'd1, 3'd2);
        insertCoin(C20);
        tick();
        checks++; if (ticketOut !== 1'b1) begin errors++; $display("[TB] FAIL t6_first_pulse: ticketOut=%b required 1", ticketOut); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (money !== 8'd0 || moneyReturn !== 8'd0 || ticketType !== 3'd0 || ticketCount !== 3'd0 || {ticketOut, coinReject, done} !== 3'b000) begin
            errors++; $display("[TB] FAIL t6_reset: money=%0d ret=%0d type=%0d count=%0d flags=%b required all 0", money, moneyReturn, ticketType, ticketCount, {ticketOut, coinReject, done});
        end
        for (int i = 0; i < 12; i++) begin
            if (ticketOut || done) extra++;
            tick();
        end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL t6_quiet: %0d active cycles required 0", extra); end
    endtask

    initial begin
        test_reset();
        test_two_tickets();
        test_change();
        test_cancel();
        test_max_money();
        test_exact_max();
        test_rejects();
        test_back_to_back();
        test_reset_mid_vend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
